serial_add_ctrl: RTL and testbench

Sequencing controller for the bit-serial adder datapath. It accepts an operand pair on a start handshake and loads the operands into its internal shift registers. It then clocks WIDTH LSB-first shift cycles through a one-bit full adder with a carry flip-flop, assembles the serial sum into a parallel result and signals completion. Its load/shift strobes are also exported, so external parallel-in/serial-out (PISO) registers stay in lockstep with it.

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_add_bit.sv | 34 +++
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state type, default width and counter sizing for the serial adder
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed for a counter that runs 0..width-1 (never narrower than one bit).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_bit.sv
// rtl/serial_add_bit.sv - one-bit full adder with its carry flip-flop
module serial_add_bit
  import serial_add_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_c,
  input  logic c_init,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  logic r_c;
  logic w_maj;

  assign s     = a ^ b ^ r_c;
  assign w_maj = (a & b) | (a & r_c) | (b & r_c);
  assign c     = r_c;

  // Carry register: seeded at operand capture, advanced once per shift cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c <= 1'b0;
    end else if (load_c) begin
      r_c <= c_init;
    end else if (en) begin
      r_c <= w_maj;
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer (optional subtract via SERIAL_ADD_SUB_EN)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             piso_load,
  output logic             piso_shift
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_piso_load;
  logic             r_piso_shift;

  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic             w_c_next;
  logic             w_c_init;
  logic [WIDTH-1:0] w_b_cap;
  logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract is A + ~B + 1: invert B on capture and force the carry seed high.
  assign w_b_cap  = sub ? ~b_in : b_in;
  assign w_c_init = sub | cin;
`else
  assign w_b_cap  = b_in;
  assign w_c_init = cin;
`endif

  assign w_accept   = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_shift    = (r_state == ST_SHIFT);
  assign w_last     = (r_bit_cnt == CW'(WIDTH - 1));
  assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
  // Carry as it will be after this shift; captured into cout on the final shift.
  assign w_c_next   = (r_opa[0] & r_opb[0]) | (r_opa[0] & w_c) | (r_opb[0] & w_c);

  serial_add_bit u_bit (
    .clk    (clk),
    .reset  (reset),
    .load_c (w_accept),
    .c_init (w_c_init),
    .en     (w_shift),
    .a      (r_opa[0]),
    .b      (r_opb[0]),
    .s      (w_s),
    .c      (w_c)
  );

  // Sequencer: state, operand shifters, bit counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_opa        <= '0;
      r_opb        <= '0;
      r_sum_sr     <= '0;
      r_sum        <= '0;
      r_bit_cnt    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cout       <= 1'b0;
      r_piso_load  <= 1'b0;
      r_piso_shift <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state     <= ST_LOAD;
            r_opa       <= a_in;
            r_opb       <= w_b_cap;
            r_sum_sr    <= '0;
            r_bit_cnt   <= '0;
            r_busy      <= 1'b1;
            r_piso_load <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          r_state      <= ST_SHIFT;
          r_piso_load  <= 1'b0;
          r_piso_shift <= 1'b1;
        end
        ST_SHIFT: begin
          r_opa     <= {1'b0, r_opa[WIDTH-1:1]};
          r_opb     <= {1'b0, r_opb[WIDTH-1:1]};
          r_sum_sr  <= w_sum_next;
          r_bit_cnt <= r_bit_cnt + CW'(1);
          if (w_last) begin
            r_state      <= ST_DONE;
            r_busy       <= 1'b0;
            r_piso_shift <= 1'b0;
            r_done       <= 1'b1;
            r_sum        <= w_sum_next;
            r_cout       <= w_c_next;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign sum        = r_sum;
  assign cout       = r_cout;
  assign piso_load  = r_piso_load;
  assign piso_shift = r_piso_shift;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl at WIDTH 4 and 16
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start4, cin4, sub4;
  logic [3:0]  a4, b4, sum4;
  logic        busy4, done4, cout4, pl4, ps4;
  logic        start16, cin16, sub16;
  logic [15:0] a16, b16, sum16;
  logic        busy16, done16, cout16, pl16, ps16;

  int passed = 0;
  int total  = 0;

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .start      (start4),
    .a_in       (a4),
    .b_in       (b4),
    .cin        (cin4),
`ifdef SERIAL_ADD_SUB_EN
    .sub        (sub4),
`endif
    .busy       (busy4),
    .done       (done4),
    .sum        (sum4),
    .cout       (cout4),
    .piso_load  (pl4),
    .piso_shift (ps4)
  );

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .start      (start16),
    .a_in       (a16),
    .b_in       (b16),
    .cin        (cin16),
`ifdef SERIAL_ADD_SUB_EN
    .sub        (sub16),
`endif
    .busy       (busy16),
    .done       (done16),
    .sum        (sum16),
    .cout       (cout16),
    .piso_load  (pl16),
    .piso_shift (ps16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [31:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    longint unsigned m, aa, bb, r;
    m  = 64'd1 << w;
    aa = a;
    bb = b;
    if (!s) begin
      r = aa + bb + c;
    end else begin
      r = (aa + m - bb) % m;
      if (aa >= bb) r = r + m;
    end
    return r[31:0];
  endfunction

  // Launch one operation with a single start pulse and observe it until done.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, output logic [31:0] res,
                        output int lat, output int nbusy, output int nshift, output int nload);
    if (w == 4) begin
      a4 = a[3:0]; b4 = b[3:0]; cin4 = c; sub4 = s; start4 = 1'b1;
    end else begin
      a16 = a; b16 = b; cin16 = c; sub16 = s; start16 = 1'b1;
    end
    tick();
    start4 = 1'b0;
    start16 = 1'b0;
    res = 32'hFFFF_FFFF;
    lat = 0; nbusy = 0; nshift = 0; nload = 0;
    for (int k = 1; k <= 3 * w + 10; k++) begin
      if (w == 4) begin
        if (busy4) nbusy++;
        if (ps4) nshift++;
        if (pl4) nload++;
        if (done4) begin lat = k; res = {27'd0, cout4, sum4}; break; end
      end else begin
        if (busy16) nbusy++;
        if (ps16) nshift++;
        if (pl16) nload++;
        if (done16) begin lat = k; res = {15'd0, cout16, sum16}; break; end
      end
      tick();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int          lat, nbusy, nshift, nload;
    int          early, quiet;
    logic [15:0] ra, rb, mask;
    logic        rc, rs;
    logic [3:0]  nxt [3];
    logic [31:0] b2b_exp [3];

    nxt[0] = 4'd1; nxt[1] = 4'd2; nxt[2] = 4'd7;
    b2b_exp[0] = 32'h02; b2b_exp[1] = 32'h04; b2b_exp[2] = 32'h0E;

    reset = 1'b1;
    start4 = 0; cin4 = 0; sub4 = 0; a4 = 0; b4 = 0;
    start16 = 0; cin16 = 0; sub16 = 0; a16 = 0; b16 = 0;
    tick();
    tick();
    check("reset4_outputs", {busy4, done4, pl4, ps4, cout4, sum4}, 32'd0);
    check("reset16_outputs", {busy16, done16, pl16, ps16, cout16, sum16}, 32'd0);
    reset = 1'b0;
    tick();

    run_op(4, 16'd5, 16'd6, 1'b0, 1'b0, res, lat, nbusy, nshift, nload);
    check("add_5_6", res, 32'h0B);
    check("add_5_6_latency", lat, 6);
    check("add_5_6_busy_cycles", nbusy, 5);
    check("add_5_6_shift_cycles", nshift, 4);
    check("add_5_6_load_cycles", nload, 1);
    tick(); tick(); tick();
    check("sum_hold_after_done", {done4, busy4, cout4, sum4}, 32'h0B);

    run_op(4, 16'd9, 16'd8, 1'b0, 1'b0, res, lat, nbusy, nshift, nload);
    check("add_9_8", res, 32'h11);
    run_op(4, 16'd15, 16'd15, 1'b1, 1'b0, res, lat, nbusy, nshift, nload);
    check("add_15_15_c1", res, 32'h1F);
    check("add_15_15_latency", lat, 6);
    tick();

    // Back-to-back with start held; operands are scrambled while busy.
    a4 = nxt[0]; b4 = nxt[0]; cin4 = 0; sub4 = 0; start4 = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      early = 0;
      for (int k = 1; k < 6; k++) begin
        if (done4) early++;
        a4 = 4'hF; b4 = 4'hD; cin4 = 1'b1;
        tick();
      end
      check($sformatf("b2b%0d_no_early_done", i), early, 0);
      check($sformatf("b2b%0d_done_at_6", i), done4, 1'b1);
      check($sformatf("b2b%0d_sum", i), {cout4, sum4}, b2b_exp[i]);
      if (i < 2) begin
        a4 = nxt[i+1]; b4 = nxt[i+1]; cin4 = 1'b0;
      end else begin
        start4 = 1'b0;
      end
      tick();
    end
    check("b2b_idle_after", {done4, busy4}, 32'd0);

    // Reset during the second shift cycle, with start asserted alongside it.
    a4 = 4'd5; b4 = 4'd6; cin4 = 0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    reset = 1'b1; start4 = 1'b1;
    tick();
    check("midshift_reset_outputs", {busy4, done4, pl4, ps4, cout4, sum4}, 32'd0);
    reset = 1'b0; start4 = 1'b0;
    quiet = 0;
    for (int k = 0; k < 8; k++) begin
      if (done4 || busy4) quiet++;
      tick();
    end
    check("midshift_reset_no_done", quiet, 0);
    run_op(4, 16'd3, 16'd4, 1'b0, 1'b0, res, lat, nbusy, nshift, nload);
    check("after_reset_3_4", res, 32'h07);
    check("after_reset_latency", lat, 6);

`ifdef SERIAL_ADD_SUB_EN
    run_op(4, 16'd3, 16'd5, 1'b0, 1'b1, res, lat, nbusy, nshift, nload);
    check("sub_3_5", res, 32'h0E);
    run_op(4, 16'd5, 16'd3, 1'b0, 1'b1, res, lat, nbusy, nshift, nload);
    check("sub_5_3", res, 32'h12);
    run_op(4, 16'd5, 16'd3, 1'b1, 1'b1, res, lat, nbusy, nshift, nload);
    check("sub_5_3_cin_ignored", res, 32'h12);
`endif

    for (int w = 4; w <= 16; w += 12) begin
      mask = (w == 4) ? 16'h000F : 16'hFFFF;
      for (int n = 0; n < 1000; n++) begin
        ra = 16'($urandom) & mask;
        rb = 16'($urandom) & mask;
        rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
        rs = 1'($urandom);
`else
        rs = 1'b0;
`endif
        run_op(w, ra, rb, rc, rs, res, lat, nbusy, nshift, nload);
        check($sformatf("rand_w%0d_%0d_result a=%0h b=%0h c=%0b s=%0b", w, n, ra, rb, rc, rs),
              res, model(w, {16'd0, ra}, {16'd0, rb}, rc, rs));
        check($sformatf("rand_w%0d_%0d_latency", w, n), lat, w + 2);
        check($sformatf("rand_w%0d_%0d_shift_cycles", w, n), nshift, w);
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
